fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port stall  input  1  hazard hold; freezes PC and IF/ID outputs.
REQ-004 SHALL have port branch_taken  input  1  redirect request from execute stage.
REQ-005 SHALL have port branch_target  input  32  redirect byte address.
REQ-006 SHALL have port imem_we  input  1  instruction-memory byte write enable.
REQ-007 SHALL have port imem_waddr  input  7  instruction-memory byte write address.
REQ-008 SHALL have port imem_wdata  input  8  instruction-memory byte write data.
REQ-009 SHALL have port pc  output  32  current fetch address.
REQ-010 SHALL have port IFIDIR  output  32  registered instruction to decode.
REQ-011 SHALL have port pc_IFIDIR  output  32  registered fetch address + 4.
REQ-012 SHALL have port if_valid  output  1  IFIDIR holds a real instruction (0 = bubble).
REQ-013 SHALL have port halted  output  1  fetch stopped on halt word.

Function
REQ-014 SHALL contain a 128 x 8 instruction memory; memory SHALL not be reset.
REQ-015 Fetched word SHALL be big-endian: byte at pc -> IFIDIR[31:24], pc+1 -> [23:16], pc+2 -> [15:8], pc+3 -> [7:0].
REQ-016 Byte index SHALL be (pc + k) mod 128; pc itself SHALL wrap modulo 2^32.
REQ-017 Per-edge priority SHALL be: branch_taken > stall > halt state > normal fetch.
REQ-018 Normal fetch: IFIDIR <= word at pc, pc_IFIDIR <= pc+4, if_valid <= 1, pc <= pc+4 (one-cycle latency).
REQ-019 Branch: pc <= {branch_target[31:2], 2'b00}, IFIDIR <= 0, pc_IFIDIR <= 0, if_valid <= 0 (one bubble); SHALL override a simultaneous stall.
REQ-020 Stall (no branch): pc, IFIDIR, pc_IFIDIR, if_valid SHALL hold; consecutive stall cycles SHALL hold indefinitely.
REQ-021 Memory write SHALL occur on rising CLK when imem_we=1, in any state including stall and halt.
REQ-022 Write and fetch of the same byte in one cycle: fetch SHALL capture the old byte.
REQ-023 FSM SHALL have states RUN and HALT; reset enters RUN.
REQ-024 RUN -> HALT SHALL occur on a normal fetch of halt word 32'hFC000000 (see REQ-029); HALT -> RUN only on branch_taken.
REQ-025 In HALT: pc SHALL hold the halt word's address, IFIDIR = 0, if_valid = 0, halted = 1.

Reset
REQ-026 While RST_N=0 (asserted asynchronously, regardless of CLK): pc = 0, IFIDIR = 0, pc_IFIDIR = 0, if_valid = 0, halted = 0, state = RUN.
REQ-027 First edge after RST_N deassertion SHALL perform a normal fetch from address 0.
REQ-028 Reset mid-stall or mid-halt SHALL discard that condition completely.

Configuration
REQ-029 Macro FETCH_HALT_EN defined: halt detection per REQ-024/025; halt word is not forwarded (IFIDIR <= 0, if_valid <= 0).
REQ-030 FETCH_HALT_EN undefined: no HALT state, 32'hFC000000 fetched as an ordinary instruction, halted tied to 0.

Verification
REQ-031 Load 0x00,0x11,0x80,0x20 at bytes 0..3; release reset -> after 1 edge IFIDIR=0x00118020, pc_IFIDIR=4, pc=4, if_valid=1.
REQ-032 stall=1 for 3 edges at pc=8 -> pc stays 8, IFIDIR unchanged; stall=0 -> next edge fetches from 8.
REQ-033 branch_taken=1, stall=1, branch_target=0x2E at pc=0x10 -> pc=0x2C, IFIDIR=0, if_valid=0; next edge fetches word at 0x2C.
REQ-034 pc=0x7C, bytes 0x7C..0x7F=0xAABBCCDD -> IFIDIR=0xAABBCCDD, pc=0x80; next fetch reads bytes 0..3.
REQ-035 FETCH_HALT_EN: word 0xFC000000 at 0x0C -> halted=1, pc=0x0C, if_valid=0 held; branch_taken to 0x00 -> halted=0, fetch resumes at 0. Without macro -> IFIDIR=0xFC000000, halted=0.
REQ-036 RST_N pulsed low between edges while pc=0x20 -> pc=0 and all outputs zero immediately, without waiting for CLK.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage with a 128 x 8 byte-addressed instruction memory.
//   Words are assembled big-endian from four consecutive bytes (index wraps
//   modulo 128). The stage drives the IF/ID pipeline register (IFIDIR,
//   pc_IFIDIR, if_valid) with one-cycle latency.
//
//   Per-edge priority: branch_taken > stall > halt state > normal fetch.
//   A branch always injects exactly one bubble and overrides a stall.
//
//   Optional feature macro: FETCH_HALT_EN
//     defined   : a fetched 32'hFC000000 is not forwarded; the stage parks in
//                 HALT with pc on the halt word until a branch is taken.
//     undefined : 32'hFC000000 is an ordinary instruction, halted is tied 0.
// -----------------------------------------------------------------------------
module fetch_stage (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        imem_we,
    input  logic [6:0]  imem_waddr,
    input  logic [7:0]  imem_wdata,
    output logic [31:0] pc,
    output logic [31:0] IFIDIR,
    output logic [31:0] pc_IFIDIR,
    output logic        if_valid,
    output logic        halted
);

`ifdef FETCH_HALT_EN
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;
`else
    typedef enum logic {
        ST_RUN = 1'b0
    } state_t;
`endif

    // Instruction memory: byte array, deliberately left without reset.
    logic [7:0]  r_mem [0:127];

    // Pipeline / control state.
    logic [31:0] r_pc;
    logic [31:0] r_ifidir;
    logic [31:0] r_pc_ifidir;
    logic        r_if_valid;
    state_t      r_state;
`ifdef FETCH_HALT_EN
    logic        r_halted;
`endif

    // Combinational fetch path.
    logic [6:0]  w_addr0;
    logic [6:0]  w_addr1;
    logic [6:0]  w_addr2;
    logic [6:0]  w_addr3;
    logic [31:0] w_word;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_pc;
    logic        w_unused_tgt_bits;

    // Byte lanes wrap inside the 128-byte array independently of pc wrap.
    assign w_addr0     = r_pc[6:0];
    assign w_addr1     = r_pc[6:0] + 7'd1;
    assign w_addr2     = r_pc[6:0] + 7'd2;
    assign w_addr3     = r_pc[6:0] + 7'd3;
    assign w_word      = {r_mem[w_addr0], r_mem[w_addr1], r_mem[w_addr2], r_mem[w_addr3]};
    assign w_pc_plus4  = r_pc + 32'd4;
    // Branch targets are forced word-aligned; the low two bits are ignored.
    assign w_branch_pc = {branch_target[31:2], 2'b00};
    assign w_unused_tgt_bits = &{1'b0, branch_target[1:0]};

    // Byte write port; the read above sees the pre-write contents this cycle.
    always_ff @(posedge CLK) begin
        if (imem_we) begin
            r_mem[imem_waddr] <= imem_wdata;
        end
    end

    // Fetch FSM and IF/ID register update with branch > stall > halt > fetch priority.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc        <= 32'd0;
            r_ifidir    <= 32'd0;
            r_pc_ifidir <= 32'd0;
            r_if_valid  <= 1'b0;
            r_state     <= ST_RUN;
`ifdef FETCH_HALT_EN
            r_halted    <= 1'b0;
`endif
        end else if (branch_taken) begin
            r_pc        <= w_branch_pc;
            r_ifidir    <= 32'd0;
            r_pc_ifidir <= 32'd0;
            r_if_valid  <= 1'b0;
            r_state     <= ST_RUN;
`ifdef FETCH_HALT_EN
            r_halted    <= 1'b0;
`endif
        end else if (stall) begin
            r_pc        <= r_pc;
            r_ifidir    <= r_ifidir;
            r_pc_ifidir <= r_pc_ifidir;
            r_if_valid  <= r_if_valid;
            r_state     <= r_state;
        end else begin
            case (r_state)
                ST_RUN: begin
`ifdef FETCH_HALT_EN
                    if (w_word == HALT_WORD) begin
                        // Park on the halt word; it is never handed to decode.
                        r_pc        <= r_pc;
                        r_ifidir    <= 32'd0;
                        r_pc_ifidir <= 32'd0;
                        r_if_valid  <= 1'b0;
                        r_state     <= ST_HALT;
                        r_halted    <= 1'b1;
                    end else begin
                        r_pc        <= w_pc_plus4;
                        r_ifidir    <= w_word;
                        r_pc_ifidir <= w_pc_plus4;
                        r_if_valid  <= 1'b1;
                        r_state     <= ST_RUN;
                        r_halted    <= 1'b0;
                    end
`else
                    r_pc        <= w_pc_plus4;
                    r_ifidir    <= w_word;
                    r_pc_ifidir <= w_pc_plus4;
                    r_if_valid  <= 1'b1;
                    r_state     <= ST_RUN;
`endif
                end
`ifdef FETCH_HALT_EN
                ST_HALT: begin
                    // Only a taken branch leaves HALT; keep emitting bubbles.
                    r_pc        <= r_pc;
                    r_ifidir    <= 32'd0;
                    r_pc_ifidir <= 32'd0;
                    r_if_valid  <= 1'b0;
                    r_state     <= ST_HALT;
                    r_halted    <= 1'b1;
                end
`endif
                default: begin
                    // Illegal state encoding: recover to RUN with a bubble.
                    r_pc        <= r_pc;
                    r_ifidir    <= 32'd0;
                    r_pc_ifidir <= 32'd0;
                    r_if_valid  <= 1'b0;
                    r_state     <= ST_RUN;
`ifdef FETCH_HALT_EN
                    r_halted    <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign IFIDIR    = r_ifidir;
    assign pc_IFIDIR = r_pc_ifidir;
    assign if_valid  = r_if_valid;
`ifdef FETCH_HALT_EN
    assign halted    = r_halted;
`else
    assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed, table-driven bench for fetch_stage. Memory is preloaded while
//   reset is held, then a vector table of {stall, branch, target} ->
//   {pc, IFIDIR, pc_IFIDIR, if_valid} is stepped one clock per entry.
//   Hand-written sequences cover same-cycle write/fetch, writes under stall,
//   the halt word (build dependent on FETCH_HALT_EN) and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        CLK;
    logic        RST_N;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_we;
    logic [6:0]  imem_waddr;
    logic [7:0]  imem_wdata;
    logic [31:0] pc;
    logic [31:0] IFIDIR;
    logic [31:0] pc_IFIDIR;
    logic        if_valid;
    logic        halted;

    int n_vec;
    int n_err;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [31:0] e_ir;
        logic [31:0] e_pcir;
        logic        e_v;
    } vec_t;

    vec_t vecs [17];

    fetch_stage dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_we       (imem_we),
        .imem_waddr    (imem_waddr),
        .imem_wdata    (imem_wdata),
        .pc            (pc),
        .IFIDIR        (IFIDIR),
        .pc_IFIDIR     (pc_IFIDIR),
        .if_valid      (if_valid),
        .halted        (halted)
    );

    // Free-running 10-unit clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] e_pc, input logic [31:0] e_ir,
                         input logic [31:0] e_pcir, input logic e_v, input logic e_h);
        n_vec++;
        if (pc !== e_pc || IFIDIR !== e_ir || pc_IFIDIR !== e_pcir ||
            if_valid !== e_v || halted !== e_h) begin
            n_err++;
            $display("FAIL %s: got pc=%h ir=%h pcir=%h v=%b h=%b, expected pc=%h ir=%h pcir=%h v=%b h=%b",
                     name, pc, IFIDIR, pc_IFIDIR, if_valid, halted, e_pc, e_ir, e_pcir, e_v, e_h);
        end
    endtask

    // One rising edge, returning at the following falling edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] t);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
    endtask

    task automatic put_byte(input logic [6:0] a, input logic [7:0] d);
        imem_we    = 1'b1;
        imem_waddr = a;
        imem_wdata = d;
        tick();
        imem_we    = 1'b0;
    endtask

    task automatic put_word(input logic [6:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            put_byte(a + 7'(k), w[31 - 8*k -: 8]);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RST_N = 1'b0;
        imem_we = 1'b0;
        imem_waddr = 7'd0;
        imem_wdata = 8'd0;
        drive(1'b0, 1'b0, 32'd0);

        //          stall br    target          pc            IFIDIR        pc_IFIDIR     valid
        vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0011_8020, 32'h0000_0004, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h8C01_0004, 32'h0000_0008, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h8C01_0004, 32'h0000_0008, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0008, 32'h8C01_0004, 32'h0000_0008, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h8C01_0004, 32'h0000_0008, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_000C, 32'h8C02_0008, 32'h0000_000C, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0010, 32'h0001_180C, 32'h0000_0010, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_002E, 32'h0000_002C, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0030, 32'hCAFE_BABE, 32'h0000_0030, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_007F, 32'h0000_007C, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0080, 32'hAABB_CCDD, 32'h0000_0080, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0084, 32'h0011_8020, 32'h0000_0084, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hAABB_CCDD, 32'h0000_0000, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 32'h0000_0014, 32'h0000_0014, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0014, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0018, 32'h1234_5678, 32'h0000_0018, 1'b1};

        // Preload the program while reset is held; outputs must stay at reset values.
        @(negedge CLK);
        put_word(7'h00, 32'h0011_8020);
        put_word(7'h04, 32'h8C01_0004);
        put_word(7'h08, 32'h8C02_0008);
        put_word(7'h0C, 32'h0001_180C);
        put_word(7'h10, 32'h0022_1820);
        put_word(7'h14, 32'h1234_5678);
        put_word(7'h1C, 32'h0FED_CBA9);
        put_word(7'h2C, 32'hCAFE_BABE);
        put_word(7'h30, 32'h0BAD_F00D);
        put_word(7'h7C, 32'hAABB_CCDD);
        check("reset_state", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        RST_N = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].stall, vecs[i].br, vecs[i].tgt);
            tick();
            check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ir, vecs[i].e_pcir, vecs[i].e_v, 1'b0);
        end

        // Write and fetch of the same byte in one cycle: fetch sees the old byte.
        drive(1'b0, 1'b1, 32'h0000_0030);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        imem_we = 1'b1; imem_waddr = 7'h30; imem_wdata = 8'h55;
        tick();
        imem_we = 1'b0;
        check("wr_same_cycle_old", 32'h34, 32'h0BAD_F00D, 32'h34, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'h0000_0030);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        tick();
        check("wr_same_cycle_new", 32'h34, 32'h55AD_F00D, 32'h34, 1'b1, 1'b0);

        // A write lands while the stage is stalled, outputs frozen meanwhile.
        drive(1'b1, 1'b0, 32'd0);
        imem_we = 1'b1; imem_waddr = 7'h31; imem_wdata = 8'h66;
        tick();
        imem_we = 1'b0;
        check("wr_under_stall_hold", 32'h34, 32'h55AD_F00D, 32'h34, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'h0000_0030);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        tick();
        check("wr_under_stall_data", 32'h34, 32'h5566_F00D, 32'h34, 1'b1, 1'b0);

        // Halt word at 0x0C (loaded under stall).
        drive(1'b1, 1'b0, 32'd0);
        put_word(7'h0C, 32'hFC00_0000);
        drive(1'b0, 1'b1, 32'h0000_000C);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        tick();
`ifdef FETCH_HALT_EN
        check("halt_enter", 32'h0C, 32'd0, 32'd0, 1'b0, 1'b1);
        tick();
        check("halt_hold", 32'h0C, 32'd0, 32'd0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 32'h0000_0000);
        tick();
        check("halt_exit_branch", 32'h00, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'd0);
        tick();
        check("halt_resume_fetch", 32'h04, 32'h0011_8020, 32'h04, 1'b1, 1'b0);
`else
        check("halt_word_plain", 32'h10, 32'hFC00_0000, 32'h10, 1'b1, 1'b0);
        tick();
        check("after_halt_word", 32'h14, 32'h0022_1820, 32'h14, 1'b1, 1'b0);
`endif

        // Asynchronous reset between edges while pc=0x20 and stalled.
        drive(1'b0, 1'b1, 32'h0000_001C);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        tick();
        check("pre_reset_fetch", 32'h20, 32'h0FED_CBA9, 32'h20, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'd0);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1 check("async_reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        drive(1'b0, 1'b0, 32'd0);
        tick();
        check("post_reset_fetch", 32'h04, 32'h0011_8020, 32'h04, 1'b1, 1'b0);

`ifdef FETCH_HALT_EN
        // Reset while halted discards the halt condition.
        drive(1'b0, 1'b1, 32'h0000_000C);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        tick();
        check("halt_before_reset", 32'h0C, 32'd0, 32'd0, 1'b0, 1'b1);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1 check("reset_in_halt", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        check("fetch_after_halt_reset", 32'h04, 32'h0011_8020, 32'h04, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
